// File: rtl/handshakes_delay_valid.sv
// Two-entry valid/ready register slice: a main register drives the downstream port
// and a skid register absorbs the one word in flight when downstream stalls.
module handshakes_delay_valid #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready,
  output logic [1:0]            occupancy,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] main_q, main_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic                  up_ready_q, up_ready_d;
  logic                  down_valid_q, down_valid_d;
  logic [15:0]           xfer_cnt_q, xfer_cnt_d;
  logic                  up_xfer;
  logic                  dn_xfer;

  assign up_xfer = up_valid & up_ready_q;
  assign dn_xfer = down_valid_q & down_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          main_d  = up_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_d = up_data;
        end else if (up_xfer) begin
          skid_d  = up_data;
          state_d = TWO;
        end else if (dn_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Upstream is blocked here, so only a drain can change anything.
        if (dn_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    up_ready_d   = (state_d != TWO);
    down_valid_d = (state_d != EMPTY);
    xfer_cnt_d   = xfer_cnt_q + {15'd0, dn_xfer};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      up_ready_q   <= 1'b0;
      down_valid_q <= 1'b0;
      xfer_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = main_q;
  assign occupancy  = state_q;
  assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_handshakes_delay_valid.sv
// Randomized and directed bench for handshakes_delay_valid, modelled as a
// capacity-2 FIFO with a registered ready.
module tb_handshakes_delay_valid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_valid = 1'b0;
  logic [7:0] up_data = 8'd0;
  logic       up_ready;
  logic       down_valid;
  logic [7:0] down_data;
  logic       down_ready = 1'b0;
  logic [1:0] occupancy;
  logic [15:0] xfer_cnt;

  handshakes_delay_valid #(.WORD_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready),
    .occupancy  (occupancy),
    .xfer_cnt   (xfer_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mq[$];
  logic        m_ready = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [7:0]  sent[$];
  logic [7:0]  got[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, log observed handshakes, advance the model, compare.
  task automatic cycle(input logic uv, input logic [7:0] ud, input logic dr, input logic rn);
    logic dn;
    logic upx;
    up_valid   = uv;
    up_data    = ud;
    down_ready = dr;
    rst_n      = rn;
    #1;
    if (rn && down_valid && dr) got.push_back(down_data);
    if (rn && uv && up_ready) sent.push_back(ud);
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_ready = 1'b0;
      m_cnt   = 16'd0;
    end else begin
      dn  = (mq.size() > 0) && dr;
      upx = uv && m_ready;
      if (dn) begin
        void'(mq.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (upx) mq.push_back(ud);
      m_ready = (mq.size() < 2);
    end
    #1;
    check_eq("up_ready", {31'd0, up_ready}, {31'd0, m_ready});
    check_eq("down_valid", {31'd0, down_valid}, {31'd0, (mq.size() > 0)});
    check_eq("occupancy", {30'd0, occupancy}, mq.size());
    check_eq("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    if (mq.size() > 0) check_eq("down_data", {24'd0, down_data}, {24'd0, mq[0]});
  endtask

  initial begin
    // Reset with up_valid high: nothing may be captured.
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    cycle(1'b1, 8'h98, 1'b0, 1'b0);
    check_eq("rst_data", {24'd0, down_data}, 32'h0);
    check_eq("rst_ready", {31'd0, up_ready}, 32'h0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    check_eq("first_edge_ready", {31'd0, up_ready}, 32'h1);
    check_eq("first_edge_ignored", {31'd0, down_valid}, 32'h0);

    // Single word latency and count.
    cycle(1'b1, 8'h11, 1'b1, 1'b1);
    check_eq("lat1_valid", {31'd0, down_valid}, 32'h1);
    check_eq("lat1_data", {24'd0, down_data}, 32'h11);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("lat1_cnt", {16'd0, xfer_cnt}, 32'h1);

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, i[7:0], 1'b1, 1'b1);
      check_eq("stream_ready", {31'd0, up_ready}, 32'h1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("stream_cnt", {16'd0, xfer_cnt}, 32'h9);

    // Backpressure fills the skid register.
    cycle(1'b1, 8'hA1, 1'b0, 1'b1);
    cycle(1'b1, 8'hA2, 1'b0, 1'b1);
    check_eq("bp_occ", {30'd0, occupancy}, 32'h2);
    check_eq("bp_ready", {31'd0, up_ready}, 32'h0);
    check_eq("bp_data", {24'd0, down_data}, 32'hA1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    check_eq("bp_stable", {24'd0, down_data}, 32'hA1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("bp_second", {24'd0, down_data}, 32'hA2);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("bp_drained", {30'd0, occupancy}, 32'h0);

    // Reset while full discards both words.
    cycle(1'b1, 8'h33, 1'b0, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b1);
    check_eq("full_occ", {30'd0, occupancy}, 32'h2);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("midrst_valid", {31'd0, down_valid}, 32'h0);
    check_eq("midrst_occ", {30'd0, occupancy}, 32'h0);
    check_eq("midrst_cnt", {16'd0, xfer_cnt}, 32'h0);
    got.delete();
    sent.delete();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("midrst_no_out", got.size(), 32'h0);

    // Random traffic against the scoreboard.
    got.delete();
    sent.delete();
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("rand_count", got.size(), sent.size());
    check_eq("rand_xfer_cnt", {16'd0, xfer_cnt}, got.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      check_eq("rand_order", {24'd0, got[i]}, {24'd0, sent[i]});

    // Counter wrap.
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    begin
      int n = 0;
      while (m_cnt != 16'hFFFE && n < 70000) begin
        cycle(1'b1, 8'($urandom), 1'b1, 1'b1);
        n++;
      end
    end
    check_eq("wrap_pre", {16'd0, xfer_cnt}, 32'hFFFE);
    cycle(1'b1, 8'h5A, 1'b1, 1'b1);
    check_eq("wrap_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("wrap_zero", {16'd0, xfer_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
